// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word per req/ack handshake and hands it to decode.
// Strictly one request in flight; the next PC is resolved from decode's redirect inputs on accept.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRdata,
  input  logic        ImemErr,
  output logic [31:0] InstrReg,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        BranchTaken,
  input  logic [15:0] BranchOffset,
  input  logic        Jump,
  input  logic [25:0] JumpAddr,
  output logic        FetchFault,
  output logic [31:0] InstrCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc_plus4;
  logic [31:0] branch_disp;
  logic [31:0] next_pc;

  // Jump keeps the region bits of the sequential PC; jump takes priority over branch.
  always_comb begin
    pc_plus4    = InstrPC + 32'd4;
    branch_disp = {{14{BranchOffset[15]}}, BranchOffset, 2'b00};
    next_pc     = pc_plus4;
    if (Jump)
      next_pc = {pc_plus4[31:28], JumpAddr, 2'b00};
    else if (BranchTaken)
      next_pc = pc_plus4 + branch_disp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ImemReq    <= 1'b0;
      ImemAddr   <= RESET_PC;
      InstrReg   <= 32'd0;
      InstrPC    <= 32'd0;
      InstrValid <= 1'b0;
      FetchFault <= 1'b0;
      InstrCount <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          ImemReq  <= 1'b1;
          ImemAddr <= RESET_PC;
          state    <= REQ;
        end
        REQ: begin
          if (ImemAck) begin
            ImemReq <= 1'b0;
            if (ImemErr) begin
              FetchFault <= 1'b1;
              state      <= FAULT;
            end else begin
              InstrReg   <= ImemRdata;
              InstrPC    <= ImemAddr;
              InstrValid <= 1'b1;
              state      <= VALID;
            end
          end
        end
        VALID: begin
          if (InstrReady) begin
            InstrValid <= 1'b0;
            InstrCount <= InstrCount + 32'd1;
            ImemAddr   <= next_pc;
            ImemReq    <= 1'b1;
            state      <= REQ;
          end
        end
        default: begin
          // Fault is terminal until reset; every output simply holds.
          state <= FAULT;
        end
      endcase
    end
  end

endmodule
